// File: rtl/bsg_link_isdr_rx_if.sv
// rtl/bsg_link_isdr_rx_if.sv - link lanes in, valid/yumi head out
interface bsg_link_isdr_rx_if #(
  parameter int width_p = 16
);
  logic               link_valid;
  logic [width_p-1:0] link_data;
  logic               valid;
  logic [width_p-1:0] data;
  logic               yumi;

  modport master (output link_valid, link_data, yumi, input valid, data);
  modport slave  (input link_valid, link_data, yumi, output valid, data);
endinterface

// File: rtl/bsg_link_isdr_rx.sv
// rtl/bsg_link_isdr_rx.sv - SDR link receive capture, FIFO and credit token return
module bsg_link_isdr_rx #(
  parameter int width_p                         = 16,
  parameter int fifo_els_p                      = 8,
  parameter int lg_credit_to_token_decimation_p = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bsg_link_isdr_rx_if.slave link,
  output logic              token_o,
  output logic              overflow_o
);
  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(fifo_els_p);

  logic               valid_r;
  logic [width_p-1:0] data_r;
  logic [ptr_w-1:0]   wptr, rptr;
  logic [cnt_w-1:0]   count;
  logic [width_p-1:0] mem [fifo_els_p];
  logic               full, empty, deq, enq, drop, tok_wrap;

  // Capture flops sit directly on the pins so the pad-to-flop timing is clean.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      valid_r <= link.link_valid;
      data_r  <= link.link_data;
    end
  end

  assign full  = (count == full_cnt);
  assign empty = (count == '0);
  assign deq   = link.yumi & ~empty;
  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign enq   = valid_r & (~full | deq);
  assign drop  = valid_r & full & ~deq;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= data_r;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  assign link.valid = ~empty;
  assign link.data  = empty ? '0 : mem[rptr];

  if (lg_credit_to_token_decimation_p == 0) begin : g_no_dec
    assign tok_wrap = 1'b1;
  end else begin : g_dec
    logic [lg_credit_to_token_decimation_p-1:0] tok_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)  tok_cnt <= '0;
      else if (deq)  tok_cnt <= tok_cnt + 1'b1;
    end

    assign tok_wrap = &tok_cnt;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)            token_o <= 1'b0;
    else if (deq && tok_wrap) token_o <= ~token_o;
  end
endmodule

// File: tb/tb_bsg_link_isdr_rx.sv
// tb/tb_bsg_link_isdr_rx.sv - randomized bench with queue reference model
module tb_bsg_link_isdr_rx;
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic token, token0, ovf_o, ovf0_o;
  int total = 0;
  int bad = 0;

  bsg_link_isdr_rx_if #(.width_p(16)) lnk ();
  bsg_link_isdr_rx_if #(.width_p(16)) lnk0 ();

  bsg_link_isdr_rx #(.width_p(16), .fifo_els_p(8), .lg_credit_to_token_decimation_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .link(lnk), .token_o(token), .overflow_o(ovf_o));

  bsg_link_isdr_rx #(.width_p(16), .fifo_els_p(8), .lg_credit_to_token_decimation_p(0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .link(lnk0), .token_o(token0), .overflow_o(ovf0_o));

  always #5 clk_i = ~clk_i;

  logic [15:0] q[$];
  logic        cap_v;
  logic [15:0] cap_d;
  int          deqs;
  logic        ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    cap_v = 1'b0;
    cap_d = '0;
    deqs  = 0;
    ovf   = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input logic [15:0] d, input logic y);
    logic deq, full;
    if (!reset_i) begin
      model_reset();
      return;
    end
    deq  = y && (q.size() > 0);
    full = (q.size() == 8);
    if (deq) begin
      void'(q.pop_front());
      deqs++;
    end
    if (cap_v) begin
      if (full && !deq) ovf = 1'b1;
      else q.push_back(cap_d);
    end
    cap_v = v;
    cap_d = d;
  endfunction

  task automatic check_all();
    logic ev;
    ev = (q.size() > 0);
    check("valid", lnk.valid, ev);
    check("data", lnk.data, ev ? q[0] : 16'h0);
    check("token_lg2", token, (deqs >> 2) & 1);
    check("overflow", ovf_o, ovf);
    check("valid_lg0", lnk0.valid, ev);
    check("token_lg0", token0, deqs & 1);
    check("overflow_lg0", ovf0_o, ovf);
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic y);
    lnk.link_valid  = v;  lnk.link_data  = d;  lnk.yumi  = y;
    lnk0.link_valid = v;  lnk0.link_data = d;  lnk0.yumi = y;
    @(posedge clk_i);
    model_edge(v, d, y);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0, q.size() > 0);
    check("drained", q.size(), 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    model_reset();
    cyc(1'b0, 16'h0, 1'b0);
    reset_i = 1'b1;
  endtask

  initial begin
    int toggles, toggles0, thr;
    logic prev, prev0;
    model_reset();

    // reset held with random pin activity
    for (int i = 0; i < 6; i++) cyc($urandom % 2, 16'($urandom), $urandom % 2);
    check("rst_valid", lnk.valid, 0);
    check("rst_data", lnk.data, 0);
    reset_i = 1'b1;

    // latency and ordering
    cyc(1'b1, 16'h0001, q.size() > 0);
    check("lat_e0", lnk.valid, 0);
    cyc(1'b1, 16'h0002, q.size() > 0);
    check("lat_e1", lnk.valid, 1);
    check("lat_e1_data", lnk.data, 16'h0001);
    for (int i = 3; i <= 5; i++) cyc(1'b1, 16'(i), q.size() > 0);
    drain();

    // fill, then drain across pointer wrap while refilling
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    check("fill_count", q.size(), 8);
    check("fill_ovf", ovf_o, 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hB000 + 16'(i), 1'b1);
    drain();

    // full with same-cycle dequeue, then full without
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0);
    cyc(1'b1, 16'hC008, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    check("full_deq_ovf", ovf_o, 0);
    cyc(1'b1, 16'hDEAD, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    check("full_drop_ovf", ovf_o, 1);
    cyc(1'b0, 16'h0, 1'b0);
    check("ovf_sticky", ovf_o, 1);
    drain();

    // token decimation
    do_reset();
    toggles = 0; toggles0 = 0; prev = token; prev0 = token0;
    for (int i = 0; i < 32; i++) begin
      if (i < 12) cyc(1'b1, 16'h1000 + 16'(i), q.size() > 0);
      else        cyc(1'b0, 16'h0, q.size() > 0);
      if (token !== prev) toggles++;
      if (token0 !== prev0) toggles0++;
      prev = token; prev0 = token0;
    end
    check("deq_total", deqs, 12);
    check("toggles_lg2", toggles, 3);
    check("toggles_lg0", toggles0, 12);

    // asynchronous reset with 5 words buffered and tok_cnt at 3
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hE000 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1);
    check("pre_rst_count", q.size(), 5);
    check("pre_rst_token", token, 1);
    #2;
    reset_i = 1'b0;
    model_reset();
    #1;
    check("async_valid", lnk.valid, 0);
    check("async_data", lnk.data, 0);
    check("async_token", token, 0);
    cyc(1'b0, 16'h0, 1'b0);
    reset_i = 1'b1;
    cyc(1'b1, 16'h5555, 1'b0);
    check("post_rst_e0", lnk.valid, 0);
    cyc(1'b0, 16'h0, 1'b0);
    check("post_rst_e1", lnk.valid, 1);
    check("post_rst_data", lnk.data, 16'h5555);
    drain();

    // randomized traffic with varying consumer rate
    for (int seg = 0; seg < 4; seg++) begin
      thr = (seg == 0) ? 90 : (seg == 1) ? 30 : (seg == 2) ? 70 : 10;
      for (int i = 0; i < 120; i++)
        cyc(($urandom % 4) != 0, 16'($urandom),
            (q.size() > 0) && ($urandom_range(0, 99) < thr));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
